// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier: N-bit operands, 2N-bit product after N RUN cycles.
// Optional MULT_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are all zero.
module shift_add_mult #(
  parameter int unsigned N = 8
) (
  input  logic           i_clk,
  input  logic           i_clear_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_busy,
  output logic           o_load,
  output logic [2*N-1:0] o_product
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [2*N-1:0]  r_mcand, w_mcand_nxt;
  logic [2*N-1:0]  r_acc, w_acc_nxt;
  logic [N-1:0]    r_mplier, w_mplier_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]    w_mplier_shift;
  logic            w_exit;

  assign w_mplier_shift = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
  // No set bits left means every further step would add nothing.
  assign w_exit = (r_cnt == CntLast) || (w_mplier_shift == '0);
`else
  assign w_exit = (r_cnt == CntLast);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_mcand_nxt  = {{N{1'b0}}, i_a};
          w_mplier_nxt = i_b;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = StRun;
        end
      end
      StRun: begin
        if (r_mplier[0]) begin
          w_acc_nxt = r_acc + r_mcand;
        end
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_shift;
        w_cnt_nxt    = r_cnt + CntW'(1);
        if (w_exit) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state  <= StIdle;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_load    = (r_state == StDone);
  assign o_product = r_acc;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult (N=8) with a product scoreboard and latency checks.
module tb_shift_add_mult;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           clear_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           load;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  shift_add_mult #(.N(N)) dut (
    .i_clk     (clk),
    .i_clear_n (clear_n),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (busy),
    .o_load    (load),
    .o_product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of edges from start acceptance to load high.
  function automatic int exp_lat(input logic [N-1:0] bb);
`ifdef MULT_EARLY_EXIT_EN
    int r = 1;
    for (int i = 0; i < N; i++) if (bb[i]) r = i + 1;
    return r;
`else
    return N;
`endif
  endfunction

  task automatic run_op(input logic [N-1:0] aa, input logic [N-1:0] bb, input string tag);
    int lat;
    bit seen;
    logic [2*N-1:0] exp_p;
    exp_p = (2*N)'(aa) * (2*N)'(bb);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(exp_p);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    lat = 0;
    seen = 0;
    while (!seen && lat < N + 3) begin
      @(posedge clk); #1;
      lat++;
      if (load) seen = 1;
    end
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat(bb)));
      check({tag, "_product"}, 32'(product), 32'(exp_q.pop_front()));
    end else begin
      check({tag, "_load_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_load_single"}, 32'(load), 32'd0);
    check({tag, "_product_hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int loads;
    int next_acc;
    bit saw_low;
    logic [2*N-1:0] held_p;
    clear_n = 1'b0; start = 1'b0; a = '0; b = '0;

    // Reset state before any clock edge
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk); clear_n = 1'b1;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy || load || product != '0) loads++;
    end
    check("idle_quiet", 32'(loads), 32'd0);

    run_op(8'd13, 8'd11, "op13x11");
    run_op(8'hFF, 8'hFF, "opFFxFF");
    run_op(8'h00, 8'hFF, "op00xFF");
    run_op(8'hFF, 8'h00, "opFFx00");
    run_op(8'h07, 8'h03, "op07x03");
    run_op(8'h81, 8'h80, "op81x80");
    run_op(8'hFF, 8'h01, "opFFx01");
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
    end

    // Async reset between edges clears a held product immediately
    run_op(8'd20, 8'd10, "pre_rst");
    #2 clear_n = 1'b0;
    #1;
    check("async_rst_product", 32'(product), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); clear_n = 1'b1;

    // Starts during RUN are ignored; b has bit 7 set so RUN is 8 cycles in every build
    @(negedge clk);
    a = 8'd5; b = 8'h87; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(16'd675);
    loads = 0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (e == 3 || e == 8) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (load) begin
        loads++;
        if (exp_q.size() > 0) check("ign_product", 32'(product), 32'(exp_q.pop_front()));
        else check("ign_extra_load", 32'd1, 32'd0);
      end
    end
    start = 1'b0;
    check("ign_load_count", 32'(loads), 32'd1);
    exp_q.delete();

    // Start held high: second acceptance N+2 edges after the first
    @(negedge clk);
    a = 8'd2; b = 8'h81; start = 1'b1;
    @(posedge clk); #1;
    saw_low = 0; next_acc = 0; held_p = '0;
    for (int i = 1; i <= 20 && next_acc == 0; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        saw_low = 1;
        held_p = product;
      end else if (saw_low) begin
        next_acc = i;
      end
    end
    check("held_interval", 32'(next_acc), 32'd10);
    check("held_product", 32'(held_p), 32'd258);
    @(negedge clk); start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;

    // Reset during RUN aborts with no load pulse
    @(negedge clk);
    a = 8'd200; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_load", 32'(load), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    loads = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (load) loads++;
    end
    @(negedge clk); clear_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (load || busy) loads++;
    end
    check("midrst_no_load", 32'(loads), 32'd0);
    run_op(8'd3, 8'd5, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add unsigned multiplier. It accepts two N-bit operands on a start strobe and computes the 2N-bit product over N cycles. It then presents the product with a one-cycle `load` strobe that drives the load input of the downstream result register. It is the upstream producer for the load/clear result register in the datapath.

## Interface
- `N`, default 8: operand width; product is 2N bits; N ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `clear_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  multiplicand, captured on accepted start.
- `b`  in  N  multiplier, captured on accepted start.
- `busy`  out  1  high in RUN and DONE.
- `load`  out  1  one-cycle strobe; product valid; wire to downstream register `load`.
- `product`  out  2N  accumulator contents.

## Operation
- State machine, registered: IDLE, RUN, DONE.
- Internal registers:
  - `mcand` (2N): multiplicand, shifted left each step.
  - `mplier` (N): multiplier, shifted right each step.
  - `acc` (2N): accumulator; drives `product` directly.
  - `cnt`: ceil(log2 N) bits.
- IDLE:
  - If `start` = 1: load `mcand` = zero-extended `a`, `mplier` = `b`, `acc` = 0, `cnt` = 0, then go to RUN.
  - Otherwise all registers hold.
- RUN, every cycle:
  - If `mplier[0]`, then `acc` += `mcand`; arithmetic is modulo 2^2N, and no overflow is possible.
  - `mcand` <<= 1, `mplier` >>= 1, `cnt` += 1.
  - Go to DONE at the edge where `cnt` = N-1. Otherwise stay in RUN.
- DONE:
  - `load` = 1 for exactly this one cycle.
  - Go unconditionally to IDLE on the next edge.
- `start` in RUN or DONE is ignored. It is not queued.
- `product` holds the last result through IDLE until the next accepted start, which clears it to 0.
- `load` and `busy` are decoded from registered state only. They have no combinational path from inputs.
- The `mplier` shift is logical (zero fill). Operands are unsigned.

## Timing
- Reset (`clear_n` low), asynchronous and immediate:
  - State = IDLE.
  - `busy` = 0, `load` = 0, `product` = 0.
  - `mcand`, `mplier` and `cnt` = 0.
- Reset mid-RUN or mid-DONE aborts the operation with no `load` pulse.
- Release of `clear_n` is assumed synchronous to `clk` by the system.
- Start accepted at edge k:
  - `busy` = 1 from edge k.
  - RUN occupies cycles k..k+N-1.
  - DONE follows edge k+N: `load` = 1 and the final `product` is valid.
  - Back in IDLE after edge k+N+1: `busy` = 0, `load` = 0.
- Latency from start edge to `load` high is N cycles. The downstream register captures at edge k+N+1.
- Back-to-back: `start` held high continuously is accepted again at edge k+N+2. The initiation interval is N+2 cycles.
- `load` is never high for two consecutive cycles.

## Configuration
- `MULT_EARLY_EXIT_EN`
  - Defined: RUN exits to DONE at the edge where the updated `mplier` is 0, or where `cnt` = N-1, whichever comes first. Minimum one RUN cycle, so `b` = 0 or `b` = 1 gives `load` at k+1. Product value is unchanged.
  - Undefined: fixed N-cycle RUN as above. `cnt` is the only exit condition.

## Test plan
- Reset, N=8:
  - Assert `clear_n` = 0 asynchronously between clock edges → `busy`, `load` and `product` are 0 immediately, with no clock edge.
  - Hold `start` = 0 → outputs stay 0 indefinitely.
- N=8, fixed latency, macro undefined:
  - `a` = 8'd13, `b` = 8'd11, `start` pulse at edge 0 → `load` = 1 only after edge 8.
  - `product` = 16'd143 from then on.
  - `busy` falls after edge 9.
- N=8, maximum operands:
  - `a` = `b` = 8'hFF → `product` = 16'hFE01.
  - `a` = 0, `b` = 8'hFF → `product` = 0.
  - Exhaustive 256×256 sweep against a reference model.
- Ignored start, N=8:
  - Pulse `start` at edges 3 and 8 with new operands → exactly one `load`.
  - Result matches the original operands.
  - `start` held high continuously → next acceptance at edge 10.
- Reset mid-operation:
  - Assert `clear_n` at cycle 4 of RUN → state IDLE, no `load` pulse.
  - After release, a fresh start with `a` = 3, `b` = 5 → `product` = 15.
- Early exit, with `MULT_EARLY_EXIT_EN`:
  - `b` = 0 → `load` after edge 1.
  - `b` = 8'h03 → `load` after edge 2.
  - `b` = 8'h80 → `load` after edge 8.
  - Products match the non-macro build in all three cases.
